// File: rtl/mips_control_hazard_scoreboard.sv
// Purpose : decode-stage hazard scoreboard; tracks EX/MEM/WB destinations, raises load-use stall,
//           registers EX forwarding selects, drives the regfile write port from the WB entry.
// Latency : stall is combinational; fwd selects 1 cycle (with EX); wb_wr_* 3 edges after issue.
// Backpressure: stall holds PC/IF-ID and bubbles EX; flush overrides stall and also bubbles EX.
//
// Ports: clk/rst_n (async active-low); id_* = decode instruction register-control bundle;
//        flush kills the decode instruction; stall, ex_fwd_a/b (0 regfile, 1 MEM, 2 WB),
//        wb_wr_en/wb_wr_addr register-file write port, stall_count saturating stall cycles.
// Build option: MIPS_HAZARD_FORWARD_EN enables forwarding; when undefined, any EX/MEM
//        dependency stalls until the producer reaches WB and ex_fwd_a/b are tied to 0.
module mips_control_hazard_scoreboard #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs_addr,
  input  logic                   id_rs_used,
  input  logic [4:0]             id_rt_addr,
  input  logic                   id_rt_used,
  input  logic [4:0]             id_wr_addr,
  input  logic                   id_wr_en,
  input  logic [1:0]             id_wr_src,
  input  logic                   flush,
  output logic                   stall,
  output logic [1:0]             ex_fwd_a,
  output logic [1:0]             ex_fwd_b,
  output logic                   wb_wr_en,
  output logic [4:0]             wb_wr_addr,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic       wr_en;
    logic [4:0] addr;
  } entry_t;

  entry_t ex_q, mem_q, wb_q, ex_d;
  logic   rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;
  logic   issue;

  // A source depends on an entry only if it is a real, non-$0 read of a live destination.
  function automatic logic hit(input entry_t e, input logic [4:0] src,
                               input logic used, input logic vld);
    return e.valid & e.wr_en & (e.addr == src) & (src != 5'd0) & used & vld;
  endfunction

  assign rs_ex_hit  = hit(ex_q,  id_rs_addr, id_rs_used, id_valid);
  assign rt_ex_hit  = hit(ex_q,  id_rt_addr, id_rt_used, id_valid);
  assign rs_mem_hit = hit(mem_q, id_rs_addr, id_rs_used, id_valid);
  assign rt_mem_hit = hit(mem_q, id_rt_addr, id_rt_used, id_valid);

  assign issue = id_valid & ~stall & ~flush;

  always_comb begin
    ex_d = '0;
    if (issue) begin
      ex_d.valid = 1'b1;
      ex_d.wr_en = id_wr_en;
      ex_d.addr  = id_wr_addr;
    end
  end

`ifdef MIPS_HAZARD_FORWARD_EN
  logic       ex_is_load_q;
  logic [1:0] fwd_a_d, fwd_b_d;

  // EX is the youngest writer so it wins over MEM; a load in EX cannot forward
  // (that case stalls), but a load already in MEM has its data and can.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit,
                                         input logic ex_load);
    if (ex_hit && !ex_load) return 2'd1;
    if (mem_hit)            return 2'd2;
    return 2'd0;
  endfunction

  // flush has priority: a killed instruction never stalls the front end.
  assign stall   = ~flush & ex_is_load_q & (rs_ex_hit | rt_ex_hit);
  assign fwd_a_d = issue ? fwd_sel(rs_ex_hit, rs_mem_hit, ex_is_load_q) : 2'd0;
  assign fwd_b_d = issue ? fwd_sel(rt_ex_hit, rt_mem_hit, ex_is_load_q) : 2'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_is_load_q <= 1'b0;
      ex_fwd_a     <= 2'd0;
      ex_fwd_b     <= 2'd0;
    end else begin
      ex_is_load_q <= issue & (id_wr_src == 2'd1);
      ex_fwd_a     <= fwd_a_d;
      ex_fwd_b     <= fwd_b_d;
    end
  end
`else
  // Without forwarding every in-flight producer ahead of WB blocks its consumers;
  // the write-data source is then irrelevant.
  logic unused_wr_src;
  assign unused_wr_src = ^id_wr_src;
  assign stall    = ~flush & (rs_ex_hit | rt_ex_hit | rs_mem_hit | rt_mem_hit);
  assign ex_fwd_a = 2'd0;
  assign ex_fwd_b = 2'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // The register file writes before it reads, so WB never needs to forward to decode.
  assign wb_wr_en   = wb_q.valid & wb_q.wr_en;
  assign wb_wr_addr = wb_q.addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {STALL_CNT_W{1'b1}})) begin
      stall_count <= stall_count + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
